gray_conv_arbiter: RTL and testbench
====================================

# gray_conv_arbiter

Shares one 4-bit binary/Gray code converter among several requesters. The block arbitrates round-robin and captures the winner's operand. It runs the conversion through a registered datapath and presents the result with a valid/ready handshake. It sits between the lab's requesting units (counters, encoders, display drivers) and the single shared converter core.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 4: operand/result width in bits.
- `IDW`, default $clog2(NREQ): width of the requester ID.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `req_data`  in  NREQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
- `req_mode`  in  NREQ  per-requester mode: 0 = binary→Gray, 1 = Gray→binary.
- `gnt`  out  NREQ  one-hot, one-cycle acceptance pulse.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  converted value.
- `out_id`  out  IDW  index of the requester that owns `out_data`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, CONVERT, HOLD.

- **IDLE**
  - If `req` is nonzero, pick the winner by searching upward from `rr_ptr`, modulo NREQ.
  - Capture the winner's operand, mode and index into registers.
  - Pulse `gnt[winner]` and go to CONVERT.
  - If `req` is zero, stay in IDLE.
- **CONVERT**
  - Register the converter output into `out_data` and the captured index into `out_id`.
  - Set `out_valid` and go to HOLD.
  - Incoming `req` is ignored.
- **HOLD**
  - Hold `out_valid`, `out_data` and `out_id` stable.
  - When `out_valid && out_ready` at an edge: clear `out_valid`, set `rr_ptr = (winner+1) mod NREQ`, go to IDLE.
- **Conversion rules**
  - Binary→Gray: `g[W-1]=b[W-1]`, `g[i]=b[i+1]^b[i]`.
  - Gray→binary: `b[W-1]=g[W-1]`, `b[i]=b[i+1]^g[i]`.
  - Results are exactly WIDTH bits; no carry or overflow exists.
- **Requester rules**
  - A requester holds `req` and stable data until its `gnt`.
  - Dropping `req` before `gnt` withdraws the request with no side effect.
  - Holding `req` after `gnt` is treated as a new request.
- **Arbitration**
  - Simultaneous requests are served in round-robin order from `rr_ptr`.
  - No requester waits more than NREQ transactions.

## Timing
- Reset values: `gnt=0`, `out_valid=0`, `out_data=0`, `out_id=0`, `busy=0`, `rr_ptr=0`, state IDLE.
- Reset asserted in any state (including mid-HOLD) clears all of the above immediately. The pending result is discarded.
- Latency, with `req` seen at edge N in IDLE:
  - `gnt` is high during cycle N..N+1.
  - `out_valid` rises after edge N+1.
  - The earliest transfer is at edge N+2.
- Throughput: at most one transaction per 3 cycles.
- `out_ready` held low stalls HOLD indefinitely; no `gnt` issues while stalled.
- `out_ready` high with `out_valid` low has no effect.

## Configuration
- `GRAY_CONV_G2B_EN`
  - Defined: Gray→binary mode is available, and `req_mode` selects per transaction.
  - Undefined: the Gray→binary logic is not built, and `req_mode` is ignored. Every transaction is binary→Gray; the port remains for interface stability.

## Structure
- Package `gray_conv_pkg` holds:
  - the state enum `arb_state_t` (IDLE, CONVERT, HOLD);
  - mode constants `MODE_B2G=1'b0` and `MODE_G2B=1'b1`;
  - default width constants.
- Sub-module `gray_conv_core` is the purely combinational converter (operand, mode → result), parameterised on WIDTH, with Gray→binary under the macro.
- The arbiter contains the FSM, the round-robin pointer, the capture registers and the output registers.

## Test plan
1. Only `req[0]`, data `4'b1011`, mode 0 → `gnt=4'b0001` for one cycle. Two edges later `out_valid=1`, `out_data=4'b1110`, `out_id=0`.
2. `req[2]`, data `4'b1110`, mode 1 (macro defined) → `out_data=4'b1011`, `out_id=2`. With the macro undefined → `out_data=4'b1001`.
3. All four `req` high continuously, `out_ready=1` → grants in order 0,1,2,3,0, spaced 3 cycles apart.
4. Single request, data `4'd15`, mode 0, `out_ready` low for 5 cycles → `out_valid`, `out_data=4'b1000` and `out_id` stable; `busy=1` and no `gnt` during the stall. Raising `out_ready` transfers, and `busy` falls next cycle.
5. `rst` pulsed during HOLD → all outputs zero asynchronously. After release, `req[3]` alone is granted, and then `req[0]` wins over `req[1]` because `rr_ptr` restarted at 0.
6. `req[1]` asserted, then dropped before its grant edge while the block is in HOLD → no `gnt[1]`, no result for ID 1.

Source files
------------

// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared types and constants for the Gray/binary converter arbiter
package gray_conv_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} arb_state_t;
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int DEF_NREQ = 4;
  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/gray_conv_core.sv
// gray_conv_core: combinational binary->Gray converter; Gray->binary only under GRAY_CONV_G2B_EN
module gray_conv_core
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] b2g;
  assign b2g = a ^ (a >> 1);
`ifdef GRAY_CONV_G2B_EN
  logic [WIDTH-1:0] g2b;
  // each binary bit is the parity of all Gray bits at or above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign g2b[i] = ^(a >> i);
  end
  assign y = (mode == MODE_G2B) ? g2b : b2g;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign y = b2g;
`endif
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin sharing of one Gray/binary converter with valid/ready output
// Gray->binary mode is built only when GRAY_CONV_G2B_EN is defined.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);
  localparam logic [IDW:0]   NR   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);
  arb_state_t state;
  logic [IDW-1:0] rr_ptr, cap_id, off, win, nxt_ptr;
  logic [IDW:0] sum;
  logic [2*NREQ-1:0] dbl;
  logic [WIDTH-1:0] cap_data, conv;
  logic cap_mode;
  // rotate requests so bit 0 is rr_ptr; lowest set bit is the winner's offset
  assign dbl = {req, req} >> rr_ptr;
  always_comb begin
    off = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (dbl[k]) off = IDW'(k);
  end
  assign sum     = {1'b0, rr_ptr} + {1'b0, off};
  assign win     = (sum >= NR) ? IDW'(sum - NR) : IDW'(sum);
  assign nxt_ptr = (cap_id == LAST) ? '0 : cap_id + 1'b1;
  assign busy    = state != IDLE;
  gray_conv_core #(.WIDTH(WIDTH)) u_core (.a(cap_data), .mode(cap_mode), .y(conv));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cap_id    <= '0;
      cap_data  <= '0;
      cap_mode  <= MODE_B2G;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          cap_id   <= win;
          cap_data <= req_data[win*WIDTH +: WIDTH];
          cap_mode <= req_mode[win];
          gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << win;
          state    <= CONVERT;
        end
        CONVERT: begin
          gnt       <= '0;
          out_data  <= conv;
          out_id    <= cap_id;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          rr_ptr    <= nxt_ptr;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [3:0] req = '0, req_mode = '0, gnt, out_data;
  logic [15:0] req_data = '0;
  logic out_valid, busy;
  logic [1:0] out_id;
  int total = 0, bad = 0;
`ifdef GRAY_CONV_G2B_EN
  localparam logic [3:0] T2_EXP = 4'b1011;
`else
  localparam logic [3:0] T2_EXP = 4'b1001;
`endif
  logic [3:0] t3_exp [4] = '{4'hA, 4'h5, 4'hD, 4'h2};

  gray_conv_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_id", 32'(out_id), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    // 1: req[0], 1011 b2g
    req = 4'b0001; req_data = 16'h000B; req_mode = 4'b0000;
    tick();
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_busy", 32'(busy), 1);
    check("t1_valid_early", 32'(out_valid), 0);
    req = '0;
    tick();
    check("t1_gnt_pulse", 32'(gnt), 0);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'b1110);
    check("t1_id", 32'(out_id), 0);
    out_ready = 1'b1;
    tick();
    check("t1_xfer_valid", 32'(out_valid), 0);
    check("t1_xfer_busy", 32'(busy), 0);
    // 2: req[2], 1110 g2b (or b2g without the macro)
    req = 4'b0100; req_data = 16'h0E00; req_mode = 4'b0100;
    tick();
    check("t2_gnt", 32'(gnt), 32'b0100);
    req = '0; req_mode = '0;
    tick();
    check("t2_valid", 32'(out_valid), 1);
    check("t2_data", 32'(out_data), 32'(T2_EXP));
    check("t2_id", 32'(out_id), 2);
    tick();
    check("t2_xfer", 32'(out_valid), 0);
    // 3: all requesting after reset, order 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; req_data = 16'h396C;
    for (int c = 1; c <= 13; c++) begin
      tick();
      check($sformatf("t3_gnt_c%0d", c), 32'(gnt), (c % 3 == 1) ? (32'd1 << ((c / 3) % 4)) : 0);
      if (c % 3 == 2) begin
        check($sformatf("t3_id_c%0d", c), 32'(out_id), (c / 3) % 4);
        check($sformatf("t3_data_c%0d", c), 32'(out_data), 32'(t3_exp[(c / 3) % 4]));
      end
    end
    req = '0;
    tick(); tick(); tick();
    // 4: stall with out_ready low; req[2] pending must not be granted
    req = 4'b0010; req_data = 16'h00F0; out_ready = 1'b0;
    tick();
    check("t4_gnt", 32'(gnt), 32'b0010);
    req = 4'b0100;
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_valid_%0d", c), 32'(out_valid), 1);
      check($sformatf("t4_data_%0d", c), 32'(out_data), 32'b1000);
      check($sformatf("t4_id_%0d", c), 32'(out_id), 1);
      check($sformatf("t4_busy_%0d", c), 32'(busy), 1);
      check($sformatf("t4_nognt_%0d", c), 32'(gnt), 0);
      tick();
    end
    req = '0; out_ready = 1'b1;
    tick();
    check("t4_xfer_valid", 32'(out_valid), 0);
    check("t4_xfer_busy", 32'(busy), 0);
    check("t4_xfer_gnt", 32'(gnt), 0);
    // 5: async reset during HOLD
    req = 4'b0100; req_data = 16'h0500; out_ready = 1'b0;
    tick();
    check("t5_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    check("t5_hold_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_data", 32'(out_data), 0);
    check("t5_rst_id", 32'(out_id), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_gnt", 32'(gnt), 0);
    tick();
    rst = 1'b0;
    req = 4'b1000; req_data = 16'h7000;
    tick();
    check("t5_gnt3", 32'(gnt), 32'b1000);
    req = 4'b0011; req_data = 16'h0021; out_ready = 1'b1;
    tick();
    check("t5_id3", 32'(out_id), 3);
    check("t5_data3", 32'(out_data), 32'b0100);
    tick();
    tick();
    check("t5_gnt0", 32'(gnt), 32'b0001);
    req = '0;
    tick(); tick();
    check("t5_drain", 32'(out_valid), 0);
    // 6: req[1] withdrawn while the block is in HOLD
    req = 4'b0001; req_data = 16'h0003; out_ready = 1'b0;
    tick();
    check("t6_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0010;
    tick();
    check("t6_hold_gnt_a", 32'(gnt), 0);
    tick();
    check("t6_hold_gnt_b", 32'(gnt), 0);
    req = '0; out_ready = 1'b1;
    tick();
    check("t6_xfer", 32'(out_valid), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t6_nognt_%0d", c), 32'(gnt), 0);
      check($sformatf("t6_novalid_%0d", c), 32'(out_valid), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
